// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with a 2-bit saturating counter per entry.
//               Combinational lookup in IF, single update per resolved
//               conditional branch in EX, mispredict/redirect generation and
//               branch / miss statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CNT_ALLOC  = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  // IF-stage lookup
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredNPCF,
  // EX-stage resolution
  input  logic [31:0] PCE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredNPCE,
  input  logic        StallE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  // statistics
  output logic [31:0] BranchCount,
  output logic [31:0] MissCount
);

  localparam int         ENTRIES  = 1 << INDEX_BITS;
  localparam int         TAG_BITS = 30 - INDEX_BITS;
  localparam logic [2:0] NOBRANCH = 3'd0;

  // Table storage: valid/cnt are reset, tag/target are only ever read
  // through a valid entry so they carry no reset.
  logic                valid_q  [ENTRIES];
  logic [1:0]          cnt_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] miss_cnt_q,   miss_cnt_d;
  logic [1:0]  cnt_d;

  logic [INDEX_BITS-1:0] w_idx_f, w_idx_e;
  logic [TAG_BITS-1:0]   w_tag_f, w_tag_e;
  logic                  w_hit_f, w_hit_e;
  logic                  w_upd;

  // PC bits [1:0] never participate in indexing or tagging.
  logic w_unused;
  assign w_unused = ^{PCF[1:0], PCE[1:0]};

  assign w_idx_f = PCF[INDEX_BITS+1:2];
  assign w_tag_f = PCF[31:INDEX_BITS+2];
  assign w_idx_e = PCE[INDEX_BITS+1:2];
  assign w_tag_e = PCE[31:INDEX_BITS+2];

  assign w_hit_f = valid_q[w_idx_f] && (tag_q[w_idx_f] == w_tag_f);
  assign w_hit_e = valid_q[w_idx_e] && (tag_q[w_idx_e] == w_tag_e);

  // Bubbles carry NOBRANCH and a stalled EX holds the same branch, so this
  // fires exactly once per resolved conditional branch.
  assign w_upd = !rst && !StallE && (BranchTypeE != NOBRANCH);

  // IF lookup: read is asynchronous, so a same-cycle update is not visible.
  always_comb begin
    PredTakenF = !rst && w_hit_f && cnt_q[w_idx_f][1];
    PredNPCF   = PredTakenF ? target_q[w_idx_f] : (PCF + 32'd4);
  end

  // EX resolution: wrong direction, or taken to a different target.
  always_comb begin
    MispredictE = w_upd && ((PredTakenE != BranchE) ||
                            (BranchE && (PredNPCE != BrTargetE)));
    RedirectPCE = BranchE ? BrTargetE : (PCE + 32'd4);
  end

  // Saturating counter step for the entry being updated.
  always_comb begin
    cnt_d = cnt_q[w_idx_e];
    if (BranchE) begin
      if (cnt_q[w_idx_e] != 2'b11) cnt_d = cnt_q[w_idx_e] + 2'd1;
    end else begin
      if (cnt_q[w_idx_e] != 2'b00) cnt_d = cnt_q[w_idx_e] - 2'd1;
    end
  end

  // Statistics next-state; both wrap naturally at 2^32.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (w_upd) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (MispredictE) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Valid bits and counters: reset to invalid / weakly-not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b01;
      end
    end else if (w_upd) begin
      if (w_hit_e) begin
        cnt_q[w_idx_e] <= cnt_d;
      end else if (BranchE) begin
        valid_q[w_idx_e] <= 1'b1;
        cnt_q[w_idx_e]   <= CNT_ALLOC;
      end
    end
  end

  // Tag/target write on any taken update (hit refresh or allocation).
  always_ff @(posedge clk) begin
    if (w_upd && BranchE) begin
      tag_q[w_idx_e]    <= w_tag_e;
      target_q[w_idx_e] <= BrTargetE;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign BranchCount = branch_cnt_q;
  assign MissCount   = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor: directed scenarios
//               plus randomized traffic against a behavioural BTB model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredNPCF;
  logic [31:0] PCE;
  logic [2:0]  BranchTypeE;
  logic        BranchE;
  logic [31:0] BrTargetE;
  logic        PredTakenE;
  logic [31:0] PredNPCE;
  logic        StallE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [31:0] BranchCount;
  logic [31:0] MissCount;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor #(.INDEX_BITS(6), .CNT_ALLOC(2'b10)) dut (
    .clk(clk), .rst(rst),
    .PCF(PCF), .PredTakenF(PredTakenF), .PredNPCF(PredNPCF),
    .PCE(PCE), .BranchTypeE(BranchTypeE), .BranchE(BranchE),
    .BrTargetE(BrTargetE), .PredTakenE(PredTakenE), .PredNPCE(PredNPCE),
    .StallE(StallE), .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .BranchCount(BranchCount), .MissCount(MissCount)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model: each entry remembers its owner PC
  logic        m_valid  [64];
  logic [31:0] m_owner  [64];
  logic [31:0] m_target [64];
  int          m_cnt    [64];
  logic [31:0] m_bcnt, m_mcnt;

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = int'(pc[7:2]);
    return m_valid[i] && (m_owner[i][31:8] == pc[31:8]);
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output logic tk,
                                   output logic [31:0] npc);
    int i;
    i   = int'(pc[7:2]);
    tk  = !rst && m_hit(pc) && (m_cnt[i] >= 2);
    npc = tk ? m_target[i] : pc + 32'd4;
  endfunction

  function automatic logic m_upd();
    return !rst && !StallE && (BranchTypeE != 3'd0);
  endfunction

  function automatic logic m_misp();
    return m_upd() && ((PredTakenE != BranchE) ||
                       (BranchE && (PredNPCE != BrTargetE)));
  endfunction

  // Apply the effect of the coming clock edge to the model, then take it.
  task automatic tick();
    int i;
    if (rst) begin
      for (int k = 0; k < 64; k++) begin
        m_valid[k] = 1'b0;
        m_cnt[k]   = 1;
      end
      m_bcnt = 0;
      m_mcnt = 0;
    end else if (m_upd()) begin
      i = int'(PCE[7:2]);
      if (m_misp()) m_mcnt = m_mcnt + 1;
      m_bcnt = m_bcnt + 1;
      if (m_hit(PCE)) begin
        if (BranchE) begin
          m_cnt[i]    = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_target[i] = BrTargetE;
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (BranchE) begin
        m_valid[i]  = 1'b1;
        m_owner[i]  = PCE;
        m_target[i] = BrTargetE;
        m_cnt[i]    = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    BranchTypeE = 3'd0; BranchE = 1'b0; StallE = 1'b0;
    PredTakenE = 1'b0; PredNPCE = 32'd0; PCE = 32'd0; BrTargetE = 32'd0;
  endtask

  task automatic branch(input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic ptk,
                        input logic [31:0] pnpc);
    PCE = pc; BranchTypeE = 3'd1; BranchE = tk; BrTargetE = tgt;
    PredTakenE = ptk; PredNPCE = pnpc; StallE = 1'b0;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    rst = 1'b1; PCF = 32'h100; idle();
    tick(); tick();
    if (PredTakenF !== 1'b0) begin n_err++;
      $display("FAIL reset_pred_in_rst got=%b exp=0", PredTakenF); end
    n_cmp++;
    rst = 1'b0;
    tick();
    PCF = 32'h100; #1;
    if (PredTakenF !== 1'b0 || PredNPCF !== 32'h104) begin n_err++;
      $display("FAIL reset_lookup_100 got=%b/%h exp=0/00000104", PredTakenF, PredNPCF); end
    n_cmp++;
    PCF = 32'h3FC; #1;
    if (PredTakenF !== 1'b0 || PredNPCF !== 32'h400) begin n_err++;
      $display("FAIL reset_lookup_3fc got=%b/%h exp=0/00000400", PredTakenF, PredNPCF); end
    n_cmp++;
    if (BranchCount !== 32'd0 || MissCount !== 32'd0) begin n_err++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", BranchCount, MissCount); end
    n_cmp++;
  endtask

  task automatic test_alloc();
    branch(32'h100, 1'b1, 32'h080, 1'b0, 32'h104); #1;
    if (MispredictE !== 1'b1 || RedirectPCE !== 32'h080) begin n_err++;
      $display("FAIL alloc_mispredict got=%b/%h exp=1/00000080", MispredictE, RedirectPCE); end
    n_cmp++;
    tick(); idle();
    PCF = 32'h100; #1;
    if (PredTakenF !== 1'b1 || PredNPCF !== 32'h080) begin n_err++;
      $display("FAIL alloc_hit got=%b/%h exp=1/00000080", PredTakenF, PredNPCF); end
    n_cmp++;
    if (MissCount !== 32'd1 || BranchCount !== 32'd1) begin n_err++;
      $display("FAIL alloc_counts got=%0d/%0d exp=1/1", BranchCount, MissCount); end
    n_cmp++;
  endtask

  task automatic test_saturation();
    logic        pt;
    logic [31:0] pn;
    for (int k = 0; k < 3; k++) begin
      m_lookup(32'h100, pt, pn);
      branch(32'h100, 1'b1, 32'h080, pt, pn); #1;
      if (MispredictE !== 1'b0) begin n_err++;
        $display("FAIL sat_taken_%0d mispredict got=%b exp=0", k, MispredictE); end
      n_cmp++;
      tick();
    end
    // first not-taken: 11 -> 10, still predicts taken
    m_lookup(32'h100, pt, pn);
    branch(32'h100, 1'b0, 32'h080, pt, pn); #1;
    if (MispredictE !== 1'b1 || RedirectPCE !== 32'h104) begin n_err++;
      $display("FAIL sat_nt1_mispredict got=%b/%h exp=1/00000104", MispredictE, RedirectPCE); end
    n_cmp++;
    tick(); idle(); PCF = 32'h100; #1;
    if (PredTakenF !== 1'b1 || PredNPCF !== 32'h080) begin n_err++;
      $display("FAIL sat_cnt10_pred got=%b/%h exp=1/00000080", PredTakenF, PredNPCF); end
    n_cmp++;
    // second not-taken: 10 -> 01, now predicts not-taken
    m_lookup(32'h100, pt, pn);
    branch(32'h100, 1'b0, 32'h080, pt, pn);
    tick(); idle(); PCF = 32'h100; #1;
    if (PredTakenF !== 1'b0 || PredNPCF !== 32'h104) begin n_err++;
      $display("FAIL sat_cnt01_pred got=%b/%h exp=0/00000104", PredTakenF, PredNPCF); end
    n_cmp++;
    // not-taken arriving with a stale taken prediction
    branch(32'h100, 1'b0, 32'h080, 1'b1, 32'h080); #1;
    if (MispredictE !== 1'b1 || RedirectPCE !== 32'h104) begin n_err++;
      $display("FAIL sat_stale_taken got=%b/%h exp=1/00000104", MispredictE, RedirectPCE); end
    n_cmp++;
    tick(); idle(); #1;
    if (MissCount !== m_mcnt || BranchCount !== m_bcnt) begin n_err++;
      $display("FAIL sat_counts got=%0d/%0d exp=%0d/%0d", BranchCount, MissCount, m_bcnt, m_mcnt); end
    n_cmp++;
  endtask

  task automatic test_alias();
    // give 0x100 a taken entry first so the replacement is observable
    branch(32'h100, 1'b1, 32'h080, 1'b0, 32'h104); tick();
    branch(32'h100, 1'b1, 32'h080, 1'b0, 32'h104); tick(); idle();
    PCF = 32'h100; #1;
    if (PredTakenF !== 1'b1) begin n_err++;
      $display("FAIL alias_pre_100 got=%b exp=1", PredTakenF); end
    n_cmp++;
    PCF = 32'h200; #1;
    if (PredTakenF !== 1'b0 || PredNPCF !== 32'h204) begin n_err++;
      $display("FAIL alias_miss_200 got=%b/%h exp=0/00000204", PredTakenF, PredNPCF); end
    n_cmp++;
    branch(32'h200, 1'b1, 32'h300, 1'b0, 32'h204); tick(); idle(); #1;
    if (PredTakenF !== 1'b1 || PredNPCF !== 32'h300) begin n_err++;
      $display("FAIL alias_hit_200 got=%b/%h exp=1/00000300", PredTakenF, PredNPCF); end
    n_cmp++;
    PCF = 32'h100; #1;
    if (PredTakenF !== 1'b0 || PredNPCF !== 32'h104) begin n_err++;
      $display("FAIL alias_evict_100 got=%b/%h exp=0/00000104", PredTakenF, PredNPCF); end
    n_cmp++;
  endtask

  task automatic test_stall();
    logic [31:0] b0;
    b0 = m_bcnt;
    PCF = 32'h180;
    branch(32'h180, 1'b1, 32'h1F0, 1'b0, 32'h184);
    StallE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (MispredictE !== 1'b0 || PredTakenF !== 1'b0 || BranchCount !== b0) begin n_err++;
        $display("FAIL stall_hold_%0d got=%b/%b/%0d exp=0/0/%0d", k, MispredictE, PredTakenF, BranchCount, b0); end
      n_cmp++;
      tick();
    end
    StallE = 1'b0; #1;
    if (MispredictE !== 1'b1) begin n_err++;
      $display("FAIL stall_release_mispredict got=%b exp=1", MispredictE); end
    n_cmp++;
    tick(); idle(); #1;
    if (BranchCount !== b0 + 32'd1 || PredTakenF !== 1'b1 || PredNPCF !== 32'h1F0) begin n_err++;
      $display("FAIL stall_single_update got=%0d/%b/%h exp=%0d/1/000001f0", BranchCount, PredTakenF, PredNPCF, b0 + 32'd1); end
    n_cmp++;
  endtask

  task automatic test_same_cycle_and_reset();
    PCF = 32'h140;
    branch(32'h140, 1'b1, 32'h040, 1'b0, 32'h144); #1;
    if (PredTakenF !== 1'b0 || PredNPCF !== 32'h144) begin n_err++;
      $display("FAIL same_cycle_pre got=%b/%h exp=0/00000144", PredTakenF, PredNPCF); end
    n_cmp++;
    tick(); idle(); #1;
    if (PredTakenF !== 1'b1 || PredNPCF !== 32'h040) begin n_err++;
      $display("FAIL same_cycle_post got=%b/%h exp=1/00000040", PredTakenF, PredNPCF); end
    n_cmp++;
    rst = 1'b1;
    branch(32'h140, 1'b1, 32'h040, 1'b0, 32'h144); #1;
    if (PredTakenF !== 1'b0 || PredNPCF !== 32'h144 || MispredictE !== 1'b0) begin n_err++;
      $display("FAIL in_reset_outputs got=%b/%h/%b exp=0/00000144/0", PredTakenF, PredNPCF, MispredictE); end
    n_cmp++;
    tick(); rst = 1'b0; idle();
    for (int k = 0; k < 4; k++) begin
      PCF = (k == 0) ? 32'h140 : (k == 1) ? 32'h200 : (k == 2) ? 32'h180 : 32'h100;
      #1;
      if (PredTakenF !== 1'b0 || PredNPCF !== PCF + 32'd4) begin n_err++;
        $display("FAIL post_reset_miss_%h got=%b/%h exp=0/%h", PCF, PredTakenF, PredNPCF, PCF + 32'd4); end
      n_cmp++;
    end
    if (BranchCount !== 32'd0 || MissCount !== 32'd0) begin n_err++;
      $display("FAIL post_reset_counts got=%0d/%0d exp=0/0", BranchCount, MissCount); end
    n_cmp++;
  endtask

  task automatic test_random();
    logic        pt, et;
    logic [31:0] pn, en;
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 99) < 2);
      PCF   = ({30'd0, 2'b00} | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2));
      PCE   = (($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2));
      BranchTypeE = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      BranchE   = $urandom_range(0, 1);
      BrTargetE = ($urandom_range(0, 3) << 4) | 32'h800;
      StallE    = ($urandom_range(0, 4) == 0);
      m_lookup(PCE, pt, pn);
      if ($urandom_range(0, 4) == 0) begin
        PredTakenE = $urandom_range(0, 1);
        PredNPCE   = PredTakenE ? BrTargetE : PCE + 32'd4;
      end else begin
        PredTakenE = pt;
        PredNPCE   = pn;
      end
      #1;
      m_lookup(PCF, et, en);
      if (PredTakenF !== et || PredNPCF !== en) begin n_err++;
        $display("FAIL rand_lookup c=%0d pc=%h got=%b/%h exp=%b/%h", c, PCF, PredTakenF, PredNPCF, et, en); end
      n_cmp++;
      if (MispredictE !== m_misp()) begin n_err++;
        $display("FAIL rand_mispredict c=%0d got=%b exp=%b", c, MispredictE, m_misp()); end
      n_cmp++;
      if (m_misp()) begin
        if (RedirectPCE !== (BranchE ? BrTargetE : PCE + 32'd4)) begin n_err++;
          $display("FAIL rand_redirect c=%0d got=%h exp=%h", c, RedirectPCE, BranchE ? BrTargetE : PCE + 32'd4); end
        n_cmp++;
      end
      if (BranchCount !== m_bcnt || MissCount !== m_mcnt) begin n_err++;
        $display("FAIL rand_counts c=%0d got=%0d/%0d exp=%0d/%0d", c, BranchCount, MissCount, m_bcnt, m_mcnt); end
      n_cmp++;
      tick();
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_saturation();
    test_alias();
    test_stall();
    test_same_cycle_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
